instr_fetch_unit: RTL and testbench

Instruction fetch stage for the single-issue MIPS core. Owns the program counter, issues word fetches to instruction memory over a req/ack handshake, and holds the fetched word in an IF/ID register whose opcode field drives the main controller. It consumes `branch`/`jump` from the controller and `zero` from the ALU to redirect the PC, squashing wrong-path fetches.

---
 rtl/mips_pkg.sv | 28 ++
 rtl/instr_fetch_unit_if.sv | 25 ++
 rtl/instr_fetch_unit_pc_target_calc.sv | 26 ++
 rtl/instr_fetch_unit.sv | 128 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS core front end.
// Fetch FSM states, IF/ID bundle and major opcodes.
package mips_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] PC_RESET = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD,
        DRAIN
    } if_state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc4;
    } if_id_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory req/ack bus.
// The fetch unit is the master; memory is the slave.
interface instr_fetch_unit_if;
    import mips_pkg::*;

    logic            req;
    logic [XLEN-1:0] addr;
    logic            ack;
    logic [XLEN-1:0] rdata;

    modport master (
        output req,
        output addr,
        input  ack,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ack,
        output rdata
    );

endinterface

// File: rtl/instr_fetch_unit_pc_target_calc.sv
// Branch/jump target computation from IF/ID contents.
// Jump wins over branch when both are asserted.
module pc_target_calc
    import mips_pkg::*;
(
    input  logic [XLEN-1:0] instr,
    input  logic [XLEN-1:0] pc_plus4,
    input  logic            branch,
    input  logic            zero,
    input  logic            jump,
    output logic [XLEN-1:0] target,
    output logic            take
);

    logic [XLEN-1:0] boff;
    logic [XLEN-1:0] btgt;
    logic [XLEN-1:0] jtgt;

    assign boff = {{14{instr[15]}}, instr[15:0], 2'b00};
    assign btgt = pc_plus4 + boff;
    assign jtgt = {pc_plus4[31:28], instr[25:0], 2'b00};

    assign take   = jump | (branch & zero);
    assign target = jump ? jtgt : btgt;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, single outstanding imem fetch, skid buffer,
// IF/ID register and squashing of wrong-path words on redirect.
module instr_fetch_unit
    import mips_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    instr_fetch_unit_if.master  imem,
    input  logic                stall,
    input  logic                branch,
    input  logic                jump,
    input  logic                zero,
    output logic [XLEN-1:0]     instr,
    output logic [5:0]          opcode,
    output logic [XLEN-1:0]     pc_plus4,
    output logic                instr_valid
);

    if_state_t       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] tgt_q, tgt_d;
    if_id_t          skid_q, skid_d;
    if_id_t          ifid_q, ifid_d;
    logic            valid_q, valid_d;

    logic [XLEN-1:0] pc_inc;
    logic [XLEN-1:0] target;
    logic            take;
    logic            consume;
    logic            redirect;
    logic            slot_free;

    pc_target_calc u_tgt (
        .instr    (ifid_q.instr),
        .pc_plus4 (ifid_q.pc4),
        .branch   (branch),
        .zero     (zero),
        .jump     (jump),
        .target   (target),
        .take     (take)
    );

    assign pc_inc    = pc_q + 32'd4;
    assign consume   = valid_q & ~stall;
    assign redirect  = consume & take;
    assign slot_free = ~valid_q | consume;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= PC_RESET;
            tgt_q   <= '0;
            skid_q  <= '0;
            ifid_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            skid_q  <= skid_d;
            ifid_q  <= ifid_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        skid_d  = skid_q;
        ifid_d  = ifid_q;
        valid_d = valid_q;
        unique case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (imem.ack) begin
                    if (redirect) begin
                        pc_d    = target;
                        valid_d = 1'b0;
                    end else if (slot_free) begin
                        ifid_d  = '{instr: imem.rdata, pc4: pc_inc};
                        valid_d = 1'b1;
                        pc_d    = pc_inc;
                    end else begin
                        skid_d  = '{instr: imem.rdata, pc4: pc_inc};
                        pc_d    = pc_inc;
                        state_d = HOLD;
                    end
                end else if (redirect) begin
                    // keep pc so the pending request stays put until acked
                    tgt_d   = target;
                    valid_d = 1'b0;
                    state_d = DRAIN;
                end else if (consume) begin
                    valid_d = 1'b0;
                end
            end
            HOLD: begin
                if (consume) begin
                    state_d = FETCH;
                    if (redirect) begin
                        valid_d = 1'b0;
                        pc_d    = target;
                    end else begin
                        ifid_d  = skid_q;
                        valid_d = 1'b1;
                    end
                end
            end
            DRAIN: begin
                valid_d = 1'b0;
                if (imem.ack) begin
                    pc_d    = tgt_q;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign imem.req    = (state_q == FETCH) | (state_q == DRAIN);
    assign imem.addr   = pc_q;
    assign instr       = ifid_q.instr;
    assign opcode      = ifid_q.instr[31:26];
    assign pc_plus4    = ifid_q.pc4;
    assign instr_valid = valid_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed runs, consumed-instruction
// scoreboard plus direct bus/state checks.
module tb_instr_fetch_unit;
    import mips_pkg::*;

    localparam logic [31:0] BEQW = {OP_BEQ, 5'd0, 5'd0, 16'h0003};
    localparam logic [31:0] JW   = {OP_J, 26'h0100000};

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall = 1'b0;
    logic        branch, jump, zero;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [31:0] pc_plus4;
    logic        instr_valid;

    logic        ack_en = 1'b1;
    logic        zero_val = 1'b0;
    logic [31:0] mem [16];

    int total = 0;
    int bad = 0;

    if_id_t expq [$];
    if_id_t sb_e;

    instr_fetch_unit_if imem ();

    instr_fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem        (imem),
        .stall       (stall),
        .branch      (branch),
        .jump        (jump),
        .zero        (zero),
        .instr       (instr),
        .opcode      (opcode),
        .pc_plus4    (pc_plus4),
        .instr_valid (instr_valid)
    );

    always #5 clk = ~clk;

    always_comb begin
        imem.ack = imem.req & ack_en;
        if (imem.addr[31:6] == 26'd0)
            imem.rdata = mem[imem.addr[5:2]];
        else
            imem.rdata = 32'h3C00_0000 | {16'h0, imem.addr[31:16]};
    end

    assign branch = (opcode == OP_BEQ);
    assign jump   = (opcode == OP_J);
    assign zero   = zero_val;

    always @(negedge clk) begin
        if (rst_n && instr_valid && !stall) begin
            total++;
            if (expq.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected got instr=%h pc4=%h",
                         instr, pc_plus4);
            end else begin
                sb_e = expq.pop_front();
                if (instr !== sb_e.instr || pc_plus4 !== sb_e.pc4) begin
                    bad++;
                    $display("FAIL sb_instr got %h/%h exp %h/%h",
                             instr, pc_plus4, sb_e.instr, sb_e.pc4);
                end
            end
        end
    end

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] i, input logic [31:0] p);
        expq.push_back('{instr: i, pc4: p});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_req", 32'(imem.req), 0);
        chk("rst_valid", 32'(instr_valid), 0);
        chk("rst_addr", imem.addr, PC_RESET);
        chk("rst_instr", instr, 0);
        chk("rst_opcode", 32'(opcode), 0);
        chk("rst_pc4", pc_plus4, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_held", 32'(imem.req), 0);
        rst_n = 1'b1;
        step();
        chk("first_req", 32'(imem.req), 1);
        chk("first_addr", imem.addr, PC_RESET);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 16; i++)
            mem[i] = 32'h2000_0000 | (32'(i) << 2);
        mem[2] = BEQW;
        #2;

        // stream, then taken beq at 0x8 -> 0x18
        push(32'h2000_0000, 32'h4);
        push(32'h2000_0004, 32'h8);
        push(BEQW, 32'hC);
        push(32'h2000_0018, 32'h1C);
        do_reset();
        step();
        chk("s_addr1", imem.addr, 32'h4);
        chk("s_instr0", instr, 32'h2000_0000);
        chk("s_pc4_0", pc_plus4, 32'h4);
        chk("s_opcode0", 32'(opcode), 32'(OP_ADDI));
        step();
        chk("s_addr2", imem.addr, 32'h8);
        chk("s_valid1", 32'(instr_valid), 1);
        chk("s_pc4_1", pc_plus4, 32'h8);
        step();
        chk("s_addr3", imem.addr, 32'hC);
        chk("s_pc4_2", pc_plus4, 32'hC);
        chk("s_beq", instr, BEQW);
        zero_val = 1'b1;
        step();
        chk("beq_tgt_addr", imem.addr, 32'h18);
        chk("beq_bubble", 32'(instr_valid), 0);
        zero_val = 1'b0;
        step();
        chk("beq_tgt_instr", instr, 32'h2000_0018);
        chk("beq_tgt_valid", 32'(instr_valid), 1);
        chk("beq_tgt_pc4", pc_plus4, 32'h1C);
        step();

        // beq not taken: fall through to 0xC, next fetch 0x10
        push(32'h2000_0000, 32'h4);
        push(32'h2000_0004, 32'h8);
        push(BEQW, 32'hC);
        push(32'h2000_000C, 32'h10);
        do_reset();
        step();
        step();
        step();
        chk("nt_beq", instr, BEQW);
        step();
        chk("nt_addr", imem.addr, 32'h10);
        chk("nt_instr", instr, 32'h2000_000C);
        step();

        // jump with fetch of 0xC outstanding
        mem[2] = JW;
        push(32'h2000_0000, 32'h4);
        push(32'h2000_0004, 32'h8);
        push(JW, 32'hC);
        push(32'h3C00_0040, 32'h0040_0004);
        do_reset();
        step();
        step();
        step();
        chk("j_instr", instr, JW);
        chk("j_addr", imem.addr, 32'hC);
        ack_en = 1'b0;
        step();
        chk("drain_req", 32'(imem.req), 1);
        chk("drain_addr", imem.addr, 32'hC);
        chk("drain_valid", 32'(instr_valid), 0);
        step();
        chk("drain_addr2", imem.addr, 32'hC);
        chk("drain_valid2", 32'(instr_valid), 0);
        ack_en = 1'b1;
        step();
        chk("j_tgt_addr", imem.addr, 32'h0040_0000);
        chk("j_tgt_req", 32'(imem.req), 1);
        chk("j_tgt_valid", 32'(instr_valid), 0);
        step();
        chk("j_tgt_instr", instr, 32'h3C00_0040);
        chk("j_tgt_pc4", pc_plus4, 32'h0040_0004);
        step();

        // stall into skid, release, then reset while in HOLD
        stall = 1'b1;
        push(32'h2000_0000, 32'h4);
        do_reset();
        step();
        chk("k_instr0", instr, 32'h2000_0000);
        chk("k_valid0", 32'(instr_valid), 1);
        step();
        chk("hold_req", 32'(imem.req), 0);
        chk("hold_instr", instr, 32'h2000_0000);
        stall = 1'b0;
        step();
        chk("skid_instr", instr, 32'h2000_0004);
        chk("skid_pc4", pc_plus4, 32'h8);
        chk("skid_next_addr", imem.addr, 32'h8);
        chk("skid_next_req", 32'(imem.req), 1);
        stall = 1'b1;
        step();
        chk("hold2_req", 32'(imem.req), 0);
        chk("hold2_valid", 32'(instr_valid), 1);
        #1;
        do_reset();

        chk("sb_drained", 32'(expq.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
